// File: rtl/max7219_pkg.sv
// Shared constants for the MAX7219 chain driver: register addresses, the
// power-up command words, and the sequencer state encoding.
package max7219_pkg;

  localparam logic [3:0] ADDR_NOOP      = 4'h0;
  localparam logic [3:0] ADDR_DECODE    = 4'h9;
  localparam logic [3:0] ADDR_INTENSITY = 4'hA;
  localparam logic [3:0] ADDR_SCANLIMIT = 4'hB;
  localparam logic [3:0] ADDR_SHUTDOWN  = 4'hC;
  localparam logic [3:0] ADDR_TEST      = 4'hF;

  localparam logic [15:0] INIT_SHUTDOWN  = {4'h0, ADDR_SHUTDOWN,  8'h01};
  localparam logic [15:0] INIT_SCANLIMIT = {4'h0, ADDR_SCANLIMIT, 8'h07};
  localparam logic [15:0] INIT_DECODE    = {4'h0, ADDR_DECODE,    8'h00};
  localparam logic [15:0] INIT_TEST      = {4'h0, ADDR_TEST,      8'h00};
  localparam int          INIT_COUNT     = 5;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    LOAD_WORD,
    SHIFT_LO,
    SHIFT_HI,
    LOAD_HOLD,
    GAP
  } state_t;

  // Wake up, scan all 8 digits, raw segment mode, set brightness, leave test mode.
  function automatic logic [15:0] init_word(input logic [2:0] idx, input logic [3:0] intensity);
    case (idx)
      3'd0:    init_word = INIT_SHUTDOWN;
      3'd1:    init_word = INIT_SCANLIMIT;
      3'd2:    init_word = INIT_DECODE;
      3'd3:    init_word = {4'h0, ADDR_INTENSITY, 4'h0, intensity};
      default: init_word = INIT_TEST;
    endcase
  endfunction

endpackage

// File: rtl/max7219_spi_shifter.sv
// Bit engine for one chain transfer: parallel load, MSB-first shift, and the
// half-period timer that shapes the serial clock.
module max7219_spi_shifter #(
  parameter int WORD_BITS = 16,
  parameter int HALF      = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 flush,
  input  logic [WORD_BITS-1:0] data,
  output logic                 sclk,
  output logic                 din,
  output logic                 busy,
  output logic                 tick,
  output logic                 done
);

  localparam int CW = $clog2(WORD_BITS + 1);
  localparam int TW = $clog2(HALF + 1);

  logic [WORD_BITS-1:0] sr;
  logic [CW-1:0]        bits_left;
  logic [TW-1:0]        timer;

  // tick marks the last cycle of a half period; done is the final falling edge.
  assign tick = busy && (timer == '0);
  assign done = tick && sclk && (bits_left == CW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      busy      <= 1'b0;
      sclk      <= 1'b0;
      din       <= 1'b0;
      timer     <= '0;
      bits_left <= '0;
    end else if (start && !busy) begin
      busy      <= 1'b1;
      sclk      <= 1'b0;
      din       <= data[WORD_BITS-1];
      timer     <= TW'(HALF - 1);
      bits_left <= CW'(WORD_BITS);
    end else if (tick) begin
      timer <= TW'(HALF - 1);
      if (!sclk) begin
        sclk <= 1'b1;
      end else begin
        sclk <= 1'b0;
        if (bits_left == CW'(1)) begin
          busy <= 1'b0;
        end else begin
          din       <= sr[WORD_BITS-1];
          bits_left <= bits_left - CW'(1);
        end
      end
    end else begin
      if (busy) timer <= timer - TW'(1);
      if (flush) din <= 1'b0;
    end
  end

  // Remaining bits, already advanced past the one currently on din.
  always_ff @(posedge clk) begin
    if (start && !busy) begin
      sr <= {data[WORD_BITS-2:0], 1'b0};
    end else if (tick && sclk && (bits_left != CW'(1))) begin
      sr <= {sr[WORD_BITS-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/max7219_serializer.sv
// Sequencer for a daisy-chained MAX7219 array: init commands once, then
// continuous 8-row refreshes from a per-frame snapshot of the input stream.
module max7219_serializer
  import max7219_pkg::*;
#(
  parameter int         DISP_ROWS    = 1,
  parameter int         DISP_COLUMNS = 1,
  parameter int         CLK_FREQ_HZ  = 100_000_000,
  parameter int         SPI_FREQ_HZ  = 1_000_000,
  parameter logic [3:0] INTENSITY    = 4'h8
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic [0:7][DISP_ROWS-1:0][DISP_COLUMNS-1:0][15:0] i_MAX7219_DataStream,
  output logic o_MAX7219_Din,
  output logic o_MAX7219_Clk,
  output logic o_MAX7219_Load,
  output logic o_Init_Done,
  output logic o_Frame_Done
);

  localparam int N         = DISP_ROWS * DISP_COLUMNS;
  localparam int WORD_BITS = 16 * N;
  localparam int HALF_RAW  = CLK_FREQ_HZ / (2 * SPI_FREQ_HZ);
  localparam int HALF      = (HALF_RAW < 1) ? 1 : HALF_RAW;
  localparam int TW        = $clog2(2 * HALF);

  state_t                state;
  logic [2:0]            cmd_idx;
  logic [2:0]            row_idx;
  logic [TW-1:0]         wait_cnt;
  logic [WORD_BITS-1:0]  shift_data;
  logic                  start;
  logic                  flush;
  logic                  busy;
  logic                  tick;
  logic                  done;
  logic [0:7][DISP_ROWS-1:0][DISP_COLUMNS-1:0][15:0] snapshot;

  assign start = (state == LOAD_WORD) && !busy;
  assign flush = (state == LOAD_HOLD) && (wait_cnt == '0);

  // Highest flat device index lands in the MSBs so it leaves the chain end first.
  always_comb begin
    shift_data = '0;
    for (int r = 0; r < DISP_ROWS; r++) begin
      for (int c = 0; c < DISP_COLUMNS; c++) begin
        shift_data[16*(r*DISP_COLUMNS+c) +: 16] =
          o_Init_Done ? snapshot[row_idx][r][c] : init_word(cmd_idx, INTENSITY);
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (state == LATCH) snapshot <= i_MAX7219_DataStream;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state          <= IDLE;
      cmd_idx        <= '0;
      row_idx        <= '0;
      wait_cnt       <= '0;
      o_MAX7219_Load <= 1'b1;
      o_Init_Done    <= 1'b0;
      o_Frame_Done   <= 1'b0;
    end else begin
      o_Frame_Done <= 1'b0;
      case (state)
        IDLE: state <= LOAD_WORD;
        LATCH: begin
          row_idx <= '0;
          state   <= LOAD_WORD;
        end
        LOAD_WORD: begin
          o_MAX7219_Load <= 1'b0;
          state          <= SHIFT_LO;
        end
        SHIFT_LO: if (tick) state <= SHIFT_HI;
        SHIFT_HI: begin
          if (tick) begin
            if (done) begin
              wait_cnt <= TW'(HALF - 1);
              state    <= LOAD_HOLD;
            end else begin
              state <= SHIFT_LO;
            end
          end
        end
        LOAD_HOLD: begin
          if (wait_cnt == '0) begin
            o_MAX7219_Load <= 1'b1;
            wait_cnt       <= TW'(2 * HALF - 1);
            state          <= GAP;
          end else begin
            wait_cnt <= wait_cnt - TW'(1);
          end
        end
        GAP: begin
          if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - TW'(1);
          end else if (!o_Init_Done) begin
            if (cmd_idx == 3'(INIT_COUNT - 1)) begin
              cmd_idx     <= '0;
              o_Init_Done <= 1'b1;
              state       <= LATCH;
            end else begin
              cmd_idx <= cmd_idx + 3'd1;
              state   <= LOAD_WORD;
            end
          end else if (row_idx == 3'd7) begin
            o_Frame_Done <= 1'b1;
            state        <= LATCH;
          end else begin
            row_idx <= row_idx + 3'd1;
            state   <= LOAD_WORD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  max7219_spi_shifter #(
    .WORD_BITS(WORD_BITS),
    .HALF     (HALF)
  ) u_shifter (
    .clk  (i_Clk),
    .rst  (i_Rst),
    .start(start),
    .flush(flush),
    .data (shift_data),
    .sclk (o_MAX7219_Clk),
    .din  (o_MAX7219_Din),
    .busy (busy),
    .tick (tick),
    .done (done)
  );

endmodule

// File: tb/tb_max7219_serializer.sv
// Bench for max7219_serializer with a two-device chain and HALF=2: a serial
// monitor reassembles each transfer and scores it against queued expectations.
module tb_max7219_serializer;

  localparam int ROWS = 1;
  localparam int COLS = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [0:7][ROWS-1:0][COLS-1:0][15:0] stream;
  logic din, sclk, load, init_done, frame_done;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  int bitcnt = 0;
  int xfer_cnt = 0;
  int run = 0;
  int since_fall = 0;
  logic prev_clk = 1'b0;
  logic prev_load = 1'b1;
  logic prev_din = 1'b0;
  logic [31:0] shreg = '0;

  max7219_serializer #(
    .DISP_ROWS   (ROWS),
    .DISP_COLUMNS(COLS),
    .CLK_FREQ_HZ (8),
    .SPI_FREQ_HZ (2),
    .INTENSITY   (4'h8)
  ) dut (
    .i_Clk               (clk),
    .i_Rst               (rst),
    .i_MAX7219_DataStream(stream),
    .o_MAX7219_Din       (din),
    .o_MAX7219_Clk       (sclk),
    .o_MAX7219_Load      (load),
    .o_Init_Done         (init_done),
    .o_Frame_Done        (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [15:0] word_a(input int r, input int dev);
    logic [15:0] base;
    base = 16'h0101 + 16'(r);
    return (dev == 1) ? (base | 16'h00A0) : base;
  endfunction

  function automatic logic [15:0] word_b(input int r, input int dev);
    return (dev == 1) ? (16'h02B0 + 16'(r)) : (16'h0240 + 16'(r));
  endfunction

  task automatic wait_xfers(input int n, input int budget, input string tag);
    int k = 0;
    while (xfer_cnt < n && k < budget) begin
      step();
      k++;
    end
    check(tag, 32'(xfer_cnt >= n), 32'd1);
  endtask

  // Serial monitor: samples on the falling system edge, away from DUT updates.
  always @(negedge clk) begin
    if (rst) begin
      bitcnt     = 0;
      run        = 0;
      since_fall = 0;
      prev_clk   = sclk;
      prev_load  = load;
      prev_din   = din;
    end else begin
      if (!sclk && prev_clk) since_fall = 0;
      else since_fall++;
      if (sclk && !prev_clk) begin
        check("din_stable_on_rise", 32'(din), 32'(prev_din));
        if (bitcnt > 0) check("clk_low_width", 32'(run), 32'd2);
        shreg = {shreg[30:0], din};
        bitcnt++;
      end
      if (!sclk && prev_clk) check("clk_high_width", 32'(run), 32'd2);
      if (sclk != prev_clk) run = 1;
      else run++;
      if (load && !prev_load) begin
        check("load_hold_after_last_fall", 32'(since_fall >= 2), 32'd1);
        check("xfer_bits", 32'(bitcnt), 32'd32);
        if (exp_q.size() > 0) check("xfer_word", shreg, exp_q.pop_front());
        else check("xfer_unexpected", 32'(exp_q.size()), 32'd1);
        xfer_cnt++;
        bitcnt = 0;
      end
      prev_clk  = sclk;
      prev_load = load;
      prev_din  = din;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    for (int r = 0; r < 8; r++) begin
      stream[r][0][1] = word_a(r, 1);
      stream[r][0][0] = word_a(r, 0);
    end
    rst = 1'b1;
    repeat (3) step();
    check("rst_din", 32'(din), 32'd0);
    check("rst_clk", 32'(sclk), 32'd0);
    check("rst_load", 32'(load), 32'd1);
    check("rst_init_done", 32'(init_done), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);

    exp_q.push_back({16'h0C01, 16'h0C01});
    exp_q.push_back({16'h0B07, 16'h0B07});
    exp_q.push_back({16'h0900, 16'h0900});
    exp_q.push_back({16'h0A08, 16'h0A08});
    exp_q.push_back({16'h0F00, 16'h0F00});
    for (int r = 0; r < 8; r++) exp_q.push_back({word_a(r, 1), word_a(r, 0)});

    rst = 1'b0;
    step();
    check("load_high_after_idle", 32'(load), 32'd1);
    step();
    check("load_falls_2_cycles", 32'(load), 32'd0);

    repeat (673) step();
    check("init_done_before", 32'(init_done), 32'd0);
    step();
    check("init_done_rise", 32'(init_done), 32'd1);
    check("init_xfers", 32'(xfer_cnt), 32'd5);

    // Change the stream partway through row 3 of the first frame.
    wait_xfers(8, 600, "reach_row3");
    repeat (20) step();
    for (int r = 0; r < 8; r++) begin
      stream[r][0][1] = word_b(r, 1);
      stream[r][0][0] = word_b(r, 0);
    end
    for (int r = 0; r < 8; r++) exp_q.push_back({word_b(r, 1), word_b(r, 0)});

    begin
      int k = 0;
      while (frame_done !== 1'b1 && k < 1200) begin
        step();
        k++;
      end
    end
    check("frame_done_seen", 32'(frame_done), 32'd1);
    check("frame_done_after_8_rows", 32'(xfer_cnt), 32'd13);
    step();
    check("frame_done_one_cycle", 32'(frame_done), 32'd0);

    wait_xfers(21, 1300, "frame2_complete");
    for (int r = 0; r < 8; r++) exp_q.push_back({word_b(r, 1), word_b(r, 0)});

    begin
      int k = 0;
      while (bitcnt < 10 && k < 300) begin
        step();
        k++;
      end
    end
    check("reach_bit10", 32'(bitcnt >= 10), 32'd1);
    rst = 1'b1;
    step();
    check("midrst_load", 32'(load), 32'd1);
    check("midrst_clk", 32'(sclk), 32'd0);
    check("midrst_din", 32'(din), 32'd0);
    check("midrst_init_done", 32'(init_done), 32'd0);
    step();
    exp_q.delete();
    exp_q.push_back({16'h0C01, 16'h0C01});
    base = xfer_cnt;
    rst = 1'b0;
    wait_xfers(base + 1, 300, "restart_first_xfer");
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
